// File: rtl/pri_tag_pkg.sv
// Shared types and sizing for the private-cache tag SRAM controller.
// An entry is {valid, tag}; the SRAM word packs way 1 above way 0.
package pri_tag_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int TAG_WIDTH  = 11;
    localparam int NB_WAYS    = 2;
    localparam int ENTRY_W    = TAG_WIDTH + 1;
    localparam int DATA_W     = NB_WAYS * ENTRY_W;
    localparam int NB_SETS    = 2 ** ADDR_WIDTH;

    typedef enum logic [3:0] {
        FLUSH,
        IDLE,
        LK_RD,
        LK_CMP,
        RF_RD,
        RF_CMP,
        RF_WR,
        INV_RD,
        INV_CMP,
        INV_WR
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } pri_tag_entry_t;

    // Active-low byte enable selecting only the given way.
    function automatic logic [NB_WAYS-1:0] way_ben(input logic way);
        return way ? 2'b01 : 2'b10;
    endfunction

    // Place an entry in its way half; the other half is driven 0.
    function automatic logic [DATA_W-1:0] place_entry(input logic way, input pri_tag_entry_t e);
        return way ? {e, {ENTRY_W{1'b0}}} : {{ENTRY_W{1'b0}}, e};
    endfunction

endpackage

// File: rtl/pri_tag_if.sv
// Request/response bundle between the private cache controller (master)
// and the tag SRAM controller (slave).
interface pri_tag_if;
    import pri_tag_pkg::*;

    logic                  flush_i;
    logic                  flush_busy_o;

    logic                  lk_valid_i;
    logic                  lk_ready_o;
    logic [ADDR_WIDTH-1:0] lk_index_i;
    logic [TAG_WIDTH-1:0]  lk_tag_i;
    logic                  lk_rsp_valid_o;
    logic                  lk_hit_o;
    logic                  lk_way_o;

    logic                  rf_valid_i;
    logic                  rf_ready_o;
    logic [ADDR_WIDTH-1:0] rf_index_i;
    logic [TAG_WIDTH-1:0]  rf_tag_i;
    logic                  rf_done_o;
    logic                  rf_way_o;

    logic                  inv_valid_i;
    logic                  inv_ready_o;
    logic [ADDR_WIDTH-1:0] inv_index_i;
    logic [TAG_WIDTH-1:0]  inv_tag_i;
    logic                  inv_done_o;

    modport master (
        output flush_i,
        output lk_valid_i, lk_index_i, lk_tag_i,
        output rf_valid_i, rf_index_i, rf_tag_i,
        output inv_valid_i, inv_index_i, inv_tag_i,
        input  flush_busy_o,
        input  lk_ready_o, lk_rsp_valid_o, lk_hit_o, lk_way_o,
        input  rf_ready_o, rf_done_o, rf_way_o,
        input  inv_ready_o, inv_done_o
    );

    modport slave (
        input  flush_i,
        input  lk_valid_i, lk_index_i, lk_tag_i,
        input  rf_valid_i, rf_index_i, rf_tag_i,
        input  inv_valid_i, inv_index_i, inv_tag_i,
        output flush_busy_o,
        output lk_ready_o, lk_rsp_valid_o, lk_hit_o, lk_way_o,
        output rf_ready_o, rf_done_o, rf_way_o,
        output inv_ready_o, inv_done_o
    );

endinterface

// File: rtl/pri_tag_cmp.sv
// Combinational tag compare over one 2-way SRAM word.
// If both ways match (should never happen) way 0 is reported.
module pri_tag_cmp
    import pri_tag_pkg::*;
(
    input  logic [DATA_W-1:0]    rdata,
    input  logic [TAG_WIDTH-1:0] tag,
    output logic                 hit,
    output logic                 hit_way,
    output logic                 has_invalid,
    output logic                 first_invalid_way
);

    pri_tag_entry_t e0;
    pri_tag_entry_t e1;
    logic           m0;
    logic           m1;

    assign e0 = rdata[ENTRY_W-1:0];
    assign e1 = rdata[DATA_W-1:ENTRY_W];

    assign m0 = e0.valid && (e0.tag == tag);
    assign m1 = e1.valid && (e1.tag == tag);

    assign hit               = m0 || m1;
    assign hit_way           = !m0 && m1;
    assign has_invalid       = !e0.valid || !e1.valid;
    assign first_invalid_way = e0.valid;

endmodule

// File: rtl/pri_tag_ctrl.sv
// Tag SRAM initiator: serialises lookup, refill, invalidate and flush onto
// the single-port 2-way tag array. All SRAM pins are driven from flops.
module pri_tag_ctrl
    import pri_tag_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    pri_tag_if.slave              req,
    output logic                  mem_cen_o,
    output logic                  mem_wen_o,
    output logic [NB_WAYS-1:0]    mem_ben_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  way_q, way_d;
    logic                  rr_q, rr_d;

    logic                  cen_d, wen_d;
    logic [NB_WAYS-1:0]    ben_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_W-1:0]     wdata_d;

    logic                  hit, hit_way, has_invalid, first_invalid_way;
    logic                  victim;
    logic                  idle;

    pri_tag_cmp u_cmp (
        .rdata             (mem_rdata_i),
        .tag               (tag_q),
        .hit               (hit),
        .hit_way           (hit_way),
        .has_invalid       (has_invalid),
        .first_invalid_way (first_invalid_way)
    );

    // Existing copy first, then first free way, then round-robin.
    assign victim = hit ? hit_way : (has_invalid ? first_invalid_way : rr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= FLUSH;
            cnt_q       <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            way_q       <= 1'b0;
            rr_q        <= 1'b0;
            mem_cen_o   <= 1'b1;
            mem_wen_o   <= 1'b1;
            mem_ben_o   <= 2'b11;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            way_q       <= way_d;
            rr_q        <= rr_d;
            mem_cen_o   <= cen_d;
            mem_wen_o   <= wen_d;
            mem_ben_o   <= ben_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        way_d   = way_q;
        rr_d    = rr_q;
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        ben_d   = 2'b11;
        addr_d  = mem_addr_o;
        wdata_d = '0;

        case (state_q)
            FLUSH: begin
                cen_d  = 1'b0;
                wen_d  = 1'b0;
                ben_d  = 2'b00;
                addr_d = cnt_q;
                cnt_d  = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(NB_SETS - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (req.flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (req.inv_valid_i) begin
                    idx_d   = req.inv_index_i;
                    tag_d   = req.inv_tag_i;
                    cen_d   = 1'b0;
                    addr_d  = req.inv_index_i;
                    state_d = INV_RD;
                end else if (req.rf_valid_i) begin
                    idx_d   = req.rf_index_i;
                    tag_d   = req.rf_tag_i;
                    cen_d   = 1'b0;
                    addr_d  = req.rf_index_i;
                    state_d = RF_RD;
                end else if (req.lk_valid_i) begin
                    idx_d   = req.lk_index_i;
                    tag_d   = req.lk_tag_i;
                    cen_d   = 1'b0;
                    addr_d  = req.lk_index_i;
                    state_d = LK_RD;
                end
            end
            LK_RD:  state_d = LK_CMP;
            LK_CMP: state_d = IDLE;
            RF_RD:  state_d = RF_CMP;
            RF_CMP: begin
                way_d   = victim;
                if (!hit && !has_invalid) rr_d = ~rr_q;
                cen_d   = 1'b0;
                wen_d   = 1'b0;
                ben_d   = way_ben(victim);
                addr_d  = idx_q;
                wdata_d = place_entry(victim, '{valid: 1'b1, tag: tag_q});
                state_d = RF_WR;
            end
            RF_WR:  state_d = IDLE;
            INV_RD: state_d = INV_CMP;
            INV_CMP: begin
                if (hit) begin
                    way_d   = hit_way;
                    cen_d   = 1'b0;
                    wen_d   = 1'b0;
                    ben_d   = way_ben(hit_way);
                    addr_d  = idx_q;
                    wdata_d = place_entry(hit_way, '{valid: 1'b0, tag: tag_q});
                    state_d = INV_WR;
                end else begin
                    state_d = IDLE;
                end
            end
            INV_WR: state_d = IDLE;
            default: begin
                state_d = FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    assign idle = (state_q == IDLE) && !req.flush_i;

    assign req.flush_busy_o   = (state_q == FLUSH);
    assign req.inv_ready_o    = idle;
    assign req.rf_ready_o     = idle && !req.inv_valid_i;
    assign req.lk_ready_o     = idle && !req.inv_valid_i && !req.rf_valid_i;

    assign req.lk_rsp_valid_o = (state_q == LK_CMP);
    assign req.lk_hit_o       = (state_q == LK_CMP) && hit;
    assign req.lk_way_o       = (state_q == LK_CMP) && hit && hit_way;

    assign req.rf_done_o      = (state_q == RF_WR);
    assign req.rf_way_o       = (state_q == RF_WR) && way_q;

    assign req.inv_done_o     = (state_q == INV_WR) || ((state_q == INV_CMP) && !hit);

endmodule
